// File: rtl/dma_engineer.sv
// rtl/dma_engineer.sv - read-side weight DMA responder serving layer fetch requests
// Optional perf_word_cnt/perf_busy_cyc ports are enabled by DMA_ENGINEER_PERF_CNT_EN.
module dma_engineer #(
    parameter int DW              = 512,
    parameter int AW              = 27,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_engineer_req,
    input  logic [AW-1:0] dma_engineer_start_addr,
    input  logic [AW-1:0] dma_engineer_length,
    output logic          dma_engineer_ack,
    output logic [DW-1:0] dma_engineer_dout,
    output logic          dma_engineer_dout_en,
    output logic          dma_engineer_dout_eop,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic          mem_rd_rdy,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          mem_rd_dvalid
`ifdef DMA_ENGINEER_PERF_CNT_EN
    ,
    output logic [31:0]   perf_word_cnt,
    output logic [31:0]   perf_busy_cyc
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_READ, S_DRAIN} state_t;

    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] OUTS_MAX = (AW+1)'(MAX_OUTSTANDING);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, len_q;
    logic [AW:0]   iss_cnt, ret_cnt, len_ext, outstanding;
    logic          rd_fire, ret_fire;

    // Counters carry one extra bit so a maximal length never wraps.
    assign len_ext     = {1'b0, len_q};
    assign outstanding = iss_cnt - ret_cnt;
    assign mem_rd_addr = addr_q + iss_cnt[AW-1:0];
    assign rd_fire     = mem_rd_en & mem_rd_rdy;
    assign ret_fire    = mem_rd_dvalid & ((state_q == S_READ) | (state_q == S_DRAIN));

    always_comb begin
        state_d          = state_q;
        dma_engineer_ack = 1'b0;
        mem_rd_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dma_engineer_req) state_d = S_ACK;
            end
            S_ACK: begin
                dma_engineer_ack = 1'b1;
                state_d          = (len_q == '0) ? S_IDLE : S_READ;
            end
            S_READ: begin
                mem_rd_en = (iss_cnt < len_ext) && (outstanding < OUTS_MAX);
                if (mem_rd_en && mem_rd_rdy && (iss_cnt + ONE == len_ext)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The eop word is already on dout when ret_cnt reaches the length.
                if (ret_cnt == len_ext) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q               <= S_IDLE;
            addr_q                <= '0;
            len_q                 <= '0;
            iss_cnt               <= '0;
            ret_cnt               <= '0;
            dma_engineer_dout     <= '0;
            dma_engineer_dout_en  <= 1'b0;
            dma_engineer_dout_eop <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && dma_engineer_req) begin
                addr_q <= dma_engineer_start_addr;
                len_q  <= dma_engineer_length;
            end
            if (state_q == S_ACK) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
            end else begin
                if (rd_fire)  iss_cnt <= iss_cnt + ONE;
                if (ret_fire) ret_cnt <= ret_cnt + ONE;
            end
            dma_engineer_dout_en  <= ret_fire;
            dma_engineer_dout_eop <= ret_fire && (ret_cnt + ONE == len_ext);
            if (ret_fire) dma_engineer_dout <= mem_rd_data;
        end
    end

`ifdef DMA_ENGINEER_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_word_cnt <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (dma_engineer_dout_en && perf_word_cnt != 32'hFFFF_FFFF)
                perf_word_cnt <= perf_word_cnt + 32'd1;
            if (state_q != S_IDLE && perf_busy_cyc != 32'hFFFF_FFFF)
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dma_engineer.md
# dma_engineer

Read-side DMA responder that serves weight-fetch requests from layer controllers. It accepts a request handshake (`dma_engineer_req`/`dma_engineer_ack`) with a start address and a length, reads that many 512-bit words from the external weight memory read port, and streams them back to the layer with `dma_engineer_dout_en`/`dma_engineer_dout_eop`. It sits between the weight memory (DDR or on-chip ROM) and each layer's weight double buffer, and is the serving end of the layer controllers' DMA interface.

## Interface
- `DW`, 512: data word width, in bits.
- `AW`, 27: address and length width, in words.
- `MAX_OUTSTANDING`, 8: maximum number of memory reads issued but not yet returned (a power of 2, at most 16).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `dma_engineer_req`  in  1  request; held high by the layer until the ack is seen.
- `dma_engineer_start_addr`  in  AW  first word address; sampled when the request is accepted.
- `dma_engineer_length`  in  AW  number of words; sampled when the request is accepted.
- `dma_engineer_ack`  out  1  one-cycle pulse: request accepted.
- `dma_engineer_dout`  out  DW  returned data word.
- `dma_engineer_dout_en`  out  1  `dma_engineer_dout` is valid. There is no backpressure.
- `dma_engineer_dout_eop`  out  1  marks the last word; asserted together with `dma_engineer_dout_en`.
- `mem_rd_en`  out  1  memory read request.
- `mem_rd_addr`  out  AW  memory read address.
- `mem_rd_rdy`  in  1  memory accepts a read in any cycle where `mem_rd_en` and `mem_rd_rdy` are both high.
- `mem_rd_data`  in  DW  memory read data.
- `mem_rd_dvalid`  in  1  `mem_rd_data` is valid. Data returns in issue order.

## Operation
State machine: IDLE → ACK → READ → DRAIN → IDLE.
- **IDLE**
  - When `dma_engineer_req`=1: latch the start address into `addr_q` and the length into `len_q`, then go to ACK.
  - The request is sampled only in IDLE.
- **ACK**
  - `dma_engineer_ack`=1 for exactly this one cycle.
  - Clear the issue counter `iss_cnt` and the return counter `ret_cnt`.
  - If `len_q`=0, go to IDLE: no data and no eop. A zero length is a legal no-op.
  - Otherwise go to READ.
- **READ**
  - `mem_rd_en`=1 while `iss_cnt`<`len_q` and outstanding (`iss_cnt`−`ret_cnt`)<`MAX_OUTSTANDING`.
  - `mem_rd_addr` = `addr_q`+`iss_cnt`, modulo 2^AW; the address wraps silently.
  - On each accepted read (`mem_rd_en`&`mem_rd_rdy`), increment `iss_cnt`.
  - When the last read is accepted (`iss_cnt` reaches `len_q`), go to DRAIN.
- **DRAIN**
  - Issue no further reads.
  - When `ret_cnt` reaches `len_q` and the final word has been output, go to IDLE.
- **Return path** (active in READ and DRAIN)
  - Each `mem_rd_dvalid` registers `mem_rd_data` into `dma_engineer_dout` and sets `dma_engineer_dout_en`=1 on the next cycle.
  - `ret_cnt` increments on each `mem_rd_dvalid`.
  - `dma_engineer_dout_eop`=1 only on the word where `ret_cnt`=`len_q`−1 at capture.
- A `mem_rd_dvalid` in IDLE or ACK is a memory protocol violation. It is ignored: no output and no counter change.
- If `dma_engineer_req` is still high on the cycle after ACK, it is not re-accepted until the engine returns to IDLE. The layer must drop the request on seeing the ack.
- Counters are AW+1 bits wide, so a length of 2^AW−1 does not overflow.

## Timing
- Reset values (all outputs 0):
  - `dma_engineer_ack`, `dma_engineer_dout_en`, `dma_engineer_dout_eop`, `mem_rd_en` = 0.
  - `dma_engineer_dout`, `mem_rd_addr` = 0.
  - State = IDLE.
- Reset asserted mid-transfer: everything returns to IDLE immediately. In-flight memory data arriving after reset is dropped.
- Request to ack: if `req` is seen in IDLE in cycle T, `dma_engineer_ack` is high in T+1 and the first `mem_rd_en` is in T+2.
- Memory return to output: `mem_rd_dvalid` in cycle R gives `dma_engineer_dout_en` in R+1.
- Back-to-back transfers: the next request can be sampled in the cycle after the eop word.
- Throughput: with `mem_rd_rdy`=1 and a memory latency below `MAX_OUTSTANDING`, the engine sustains one word per cycle.

## Configuration
- `DMA_ENGINEER_PERF_CNT_EN`
  - When defined: adds output `perf_word_cnt` (32 bits, reset 0). It increments on every `dma_engineer_dout_en` and saturates at 0xFFFFFFFF.
  - Also adds output `perf_busy_cyc` (32 bits, reset 0). It increments on every cycle not in IDLE and also saturates.
  - When undefined: neither port nor its counter exists. Transfer behaviour is identical either way.

## Test plan
- **Single transfer.** Start address 52, length 100, `mem_rd_rdy`=1, memory latency 2.
  - Exactly one ack.
  - Reads to addresses 52..151.
  - 100 words of `dout_en` in order, with eop only on word 100.
- **Backpressure.** `mem_rd_rdy` toggles randomly, memory latency 12, `MAX_OUTSTANDING`=8.
  - Outstanding reads never exceed 8.
  - Data arrives in order and the eop count is 1.
- **Zero length.** Length 0.
  - Ack pulse, then return to IDLE.
  - No `mem_rd_en` and no `dout_en`.
- **Length 1 and back-to-back.** Length 1 at address 0x7FFFFFF, then a new request held high.
  - The single read is to 0x7FFFFFF; its word has `dout_en` and eop together.
  - The second ack arrives in the cycle after that eop + 1.
- **Reset mid-transfer.** Assert reset after 10 of 100 words.
  - All outputs are 0 immediately.
  - A late `mem_rd_dvalid` produces no output.
  - A new request then completes normally.
- **Performance counters** (`DMA_ENGINEER_PERF_CNT_EN` defined). After the single-transfer scenario, `perf_word_cnt`=100.
